// File: rtl/tdm_demuxer16_if.sv
// Serial slot stream in, rebuilt parallel frame and status out.
interface tdm_demuxer16_if #(
  parameter int unsigned N = 16
);
  localparam int unsigned SEL_W = $clog2(N);

  logic             in_bit;
  logic             in_valid;
  logic             sof;
  logic [N-1:0]     out;
  logic             out_valid;
  logic [SEL_W-1:0] sel;
  logic             frame_err;

  modport master (
    output in_bit, in_valid, sof,
    input  out, out_valid, sel, frame_err
  );

  modport slave (
    input  in_bit, in_valid, sof,
    output out, out_valid, sel, frame_err
  );
endinterface

// File: rtl/tdm_demuxer16.sv
// TDM demuxer: collects N serial slot bits into a parallel word.
// Slot k lands in out[k]; bad framing is flagged and the partial frame dropped.
module tdm_demuxer16 #(
  parameter int unsigned N = 16
) (
  input logic             clk,
  input logic             rst,
  tdm_demuxer16_if.slave  bus
);
  localparam int unsigned SEL_W = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] slot_q, slot_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [N-1:0]     out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;

  // State and datapath registers; reset discards any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      shadow_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state and slot capture; pulses default low so they last one cycle.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.sof) begin
            shadow_d[0] = bus.in_bit;
            slot_d      = SEL_W'(1);
            state_d     = RECV;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (bus.in_valid) begin
          if (bus.sof) begin
            // Premature start: drop partial frame, this beat is the new slot 0.
            frame_err_d = 1'b1;
            shadow_d[0] = bus.in_bit;
            slot_d      = SEL_W'(1);
          end else begin
            shadow_d[slot_q] = bus.in_bit;
            if (slot_q == SEL_W'(N - 1)) begin
              out_d          = shadow_q;
              out_d[N-1]     = bus.in_bit;
              out_valid_d    = 1'b1;
              slot_d         = '0;
              state_d        = IDLE;
            end else begin
              slot_d = slot_q + SEL_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel       = slot_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_tdm_demuxer16.sv
// Bench for tdm_demuxer16: vector table, directed sequences, random traffic vs model.
module tb_tdm_demuxer16;
  logic clk = 1'b0;
  logic rst = 1'b1;

  tdm_demuxer16_if #(.N(16)) bus();

  tdm_demuxer16 #(.N(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int last_valid_cyc = -1;
  int valid_gap      = 0;
  int err_seen       = 0;
  int valid_seen     = 0;

  // Reference model: count of slots gathered so far (0 = waiting for sof).
  int          m_cnt = 0;
  bit          m_bits [16];
  logic [15:0] m_out = '0;
  bit          m_valid = 0;
  bit          m_err = 0;

  typedef struct {
    logic        v;
    logic        s;
    logic        b;
    logic [15:0] eout;
    logic        evalid;
    logic [3:0]  esel;
    logic        eerr;
  } vec_t;

  vec_t tbl [16];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void model_step(bit r, bit v, bit s, bit b);
    m_valid = 0;
    m_err   = 0;
    if (r) begin
      m_cnt = 0;
      m_out = '0;
    end else if (v) begin
      if (s) begin
        if (m_cnt != 0) m_err = 1;
        m_bits[0] = b;
        m_cnt = 1;
      end else if (m_cnt == 0) begin
        m_err = 1;
      end else begin
        m_bits[m_cnt] = b;
        m_cnt++;
        if (m_cnt == 16) begin
          for (int k = 0; k < 16; k++) m_out[k] = m_bits[k];
          m_valid = 1;
          m_cnt = 0;
        end
      end
    end
  endfunction

  // One clock: drive, step model, sample #1 after the edge and compare.
  task automatic cycle(bit r, bit v, bit s, bit b);
    rst          = r;
    bus.in_valid = v;
    bus.sof      = s;
    bus.in_bit   = b;
    model_step(r, v, s, b);
    @(posedge clk);
    #1;
    cyc++;
    if (bus.out_valid === 1'b1) begin
      valid_seen++;
      if (last_valid_cyc >= 0) valid_gap = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
    end
    if (bus.frame_err === 1'b1) err_seen++;
    check("out",       32'(bus.out),       32'(m_out));
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("sel",       32'(bus.sel),       32'(m_cnt));
    check("frame_err", 32'(bus.frame_err), 32'(m_err));
    if (bus.out_valid === 1'b1 && bus.frame_err === 1'b1)
      check("valid_and_err_exclusive", 32'd1, 32'd0);
  endtask

  task automatic send_frame(logic [15:0] w);
    for (int k = 0; k < 16; k++) cycle(1'b0, 1'b1, k == 0, w[k]);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] w;
    int vs;
    int es;
    bus.in_valid = 1'b0;
    bus.sof      = 1'b0;
    bus.in_bit   = 1'b0;

    // Reset state
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_out", 32'(bus.out), 32'h0);
    check("reset_sel", 32'(bus.sel), 32'h0);

    // Table: frame 16'h900D straight after reset
    w = 16'h900D;
    for (int i = 0; i < 16; i++) begin
      tbl[i].v      = 1'b1;
      tbl[i].s      = (i == 0);
      tbl[i].b      = w[i];
      tbl[i].eout   = (i == 15) ? 16'h900D : 16'h0000;
      tbl[i].evalid = (i == 15);
      tbl[i].esel   = 4'((i + 1) % 16);
      tbl[i].eerr   = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, tbl[i].v, tbl[i].s, tbl[i].b);
      check("tbl_out",   32'(bus.out),       32'(tbl[i].eout));
      check("tbl_valid", 32'(bus.out_valid), 32'(tbl[i].evalid));
      check("tbl_sel",   32'(bus.sel),       32'(tbl[i].esel));
      check("tbl_err",   32'(bus.frame_err), 32'(tbl[i].eerr));
    end
    idle(1);
    check("valid_one_cycle", 32'(bus.out_valid), 32'h0);

    // Same frame with a 5-cycle gap after slot 7
    w = 16'h900D;
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, k == 0, w[k]);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("gap_sel_8", 32'(bus.sel), 32'd8);
    end
    for (int k = 8; k < 16; k++) cycle(1'b0, 1'b1, 1'b0, w[k]);
    check("gap_out", 32'(bus.out), 32'h900D);
    check("gap_valid", 32'(bus.out_valid), 32'h1);

    // Zero-gap back-to-back frames
    idle(2);
    send_frame(16'hA5A5);
    check("b2b_first", 32'(bus.out), 32'hA5A5);
    send_frame(16'h0F0F);
    check("b2b_second", 32'(bus.out), 32'h0F0F);
    check("b2b_spacing", 32'(valid_gap), 32'd16);

    // Good frame, aborted frame at slot 9, then full frame from that sof
    idle(1);
    send_frame(16'h1234);
    es = err_seen;
    vs = valid_seen;
    w = 16'h5555;
    for (int k = 0; k < 9; k++) cycle(1'b0, 1'b1, k == 0, w[k]);
    w = 16'hFFFF;
    for (int k = 0; k < 15; k++) begin
      cycle(1'b0, 1'b1, k == 0, w[k]);
      if (k == 0 || k == 14) check("abort_hold_out", 32'(bus.out), 32'h1234);
    end
    cycle(1'b0, 1'b1, 1'b0, w[15]);
    check("abort_final_out", 32'(bus.out), 32'hFFFF);
    check("abort_err_once", 32'(err_seen - es), 32'd1);
    check("abort_valid_once", 32'(valid_seen - vs), 32'd1);

    // Beats without sof while idle
    es = err_seen;
    vs = valid_seen;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      check("stray_sel", 32'(bus.sel), 32'd0);
      check("stray_out", 32'(bus.out), 32'hFFFF);
    end
    check("stray_err_count", 32'(err_seen - es), 32'd3);
    check("stray_no_valid", 32'(valid_seen - vs), 32'd0);

    // Reset at slot 10, then a clean frame
    w = 16'h3C3C;
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, k == 0, w[k]);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("mid_rst_out", 32'(bus.out), 32'h0);
    check("mid_rst_sel", 32'(bus.sel), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("mid_rst_idle_err", 32'(bus.frame_err), 32'h1);
    send_frame(16'h8001);
    check("after_rst_frame", 32'(bus.out), 32'h8001);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, v, s, b;
      r = ($urandom % 400) == 0;
      v = ($urandom % 4) != 0;
      s = (m_cnt == 0) ? (($urandom % 8) != 0) : (($urandom % 40) == 0);
      b = 1'($urandom);
      cycle(r, v, s, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
